// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM, and a one-deep
// valid/ready holding register with framing-error and overrun pulses.
module uart_receiver #(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int unsigned CntW             = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CntW-1:0] SymbolLast   = CntW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CntW-1:0] SampleLast   = CntW'(SAMPLE_TIME - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic            sync1_q, rx_q;
    logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            fe_q, fe_d;
    logic            ovr_q, ovr_d;
    logic            sym_tick, byte_done, accept;

    assign sym_tick = (clk_cnt_q == SymbolLast);
    assign accept   = valid_q && data_out_ready;

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            rx_q      <= 1'b1;
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync1_q   <= serial_in;
            rx_q      <= sync1_q;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            ovr_q     <= ovr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!rx_q) state_d = StStart;
            StStart: if (clk_cnt_q == SampleLast) state_d = rx_q ? StIdle : StData;
            StData:  if (sym_tick && bit_cnt_q == 3'd7) state_d = StStop;
            StStop:  if (sym_tick) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Counters, shifter and handshake register
    always_comb begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (state_d != state_q || sym_tick || state_q == StIdle) clk_cnt_d = '0;

        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        if (state_q == StIdle) bit_cnt_d = '0;
        if (state_q == StData && sym_tick) begin
            shift_d   = {rx_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end

        byte_done = (state_q == StStop) && sym_tick && rx_q;
        fe_d      = (state_q == StStop) && sym_tick && !rx_q;

        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (byte_done) begin
            // A byte landing on the acceptance cycle refills the register seamlessly.
            if (!valid_q || accept) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    // Outputs
    always_comb begin
        data_out       = data_q;
        data_out_valid = valid_q;
        framing_error  = fe_q;
        overrun        = ovr_q;
        busy           = (state_q != StIdle);
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 10 clocks per bit.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serial_in = 1'b1;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready = 1'b0;
    logic       framing_error;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int vrise_cnt = 0;
    int vrise_cyc = 0;
    int start_cyc = 0;
    logic prev_valid = 1'b0;

    uart_receiver #(
        .CLOCK_FREQ(1_000_000),
        .BAUD_RATE (100_000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .framing_error (framing_error),
        .overrun       (overrun),
        .busy          (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse and valid-edge monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (framing_error) fe_cnt <= fe_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (data_out_valid && !prev_valid) begin
            vrise_cnt <= vrise_cnt + 1;
            vrise_cyc <= cyc;
        end
        prev_valid <= data_out_valid;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        serial_in = 1'b0;
        start_cyc = cyc;
        cycles(10);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            cycles(10);
        end
        serial_in = stop;
        cycles(10);
        serial_in = 1'b1;
    endtask

    task automatic pulse_ready();
        data_out_ready = 1'b1;
        cycles(1);
        data_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycles(10);
        n_checks++;
        if ({data_out, data_out_valid, framing_error, overrun, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h v=%b fe=%b ov=%b busy=%b, want all 0",
                     data_out, data_out_valid, framing_error, overrun, busy);
        end
        rst_n = 1'b1;
        cycles(100);
        n_checks++;
        if (data_out_valid !== 1'b0 || busy !== 1'b0 || data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL idle_after_reset: got v=%b busy=%b data=%h, want 0 0 00",
                     data_out_valid, busy, data_out);
        end
    endtask

    task automatic test_basic();
        int r0, f0;
        r0 = vrise_cnt;
        f0 = fe_cnt;
        send_frame(8'hA5, 1'b1);
        cycles(2);
        n_checks++;
        if (vrise_cnt !== r0 + 1) begin
            n_fail++;
            $display("FAIL basic_valid_rise: got %0d rises, want 1", vrise_cnt - r0);
        end
        n_checks++;
        if (vrise_cyc - start_cyc < 98 || vrise_cyc - start_cyc > 100) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles, want 98..100", vrise_cyc - start_cyc);
        end
        n_checks++;
        if (data_out !== 8'hA5 || data_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_data: got %h v=%b, want a5 v=1", data_out, data_out_valid);
        end
        cycles(20);
        n_checks++;
        if (data_out !== 8'hA5 || data_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_hold: got %h v=%b, want a5 v=1", data_out, data_out_valid);
        end
        pulse_ready();
        n_checks++;
        if (data_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_accept: got v=%b, want 0", data_out_valid);
        end
        n_checks++;
        if (fe_cnt !== f0) begin
            n_fail++;
            $display("FAIL basic_no_fe: got %0d pulses, want 0", fe_cnt - f0);
        end
    endtask

    task automatic test_glitch();
        int r0, f0;
        r0 = vrise_cnt;
        f0 = fe_cnt;
        serial_in = 1'b0;
        cycles(3);
        serial_in = 1'b1;
        cycles(2);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy: got busy=%b, want 1", busy);
        end
        cycles(20);
        n_checks++;
        if (busy !== 1'b0 || data_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_idle: got busy=%b v=%b, want 0 0", busy, data_out_valid);
        end
        n_checks++;
        if (vrise_cnt !== r0 || fe_cnt !== f0) begin
            n_fail++;
            $display("FAIL glitch_quiet: got %0d rises %0d fe, want 0 0",
                     vrise_cnt - r0, fe_cnt - f0);
        end
    endtask

    task automatic test_framing();
        int r0, f0;
        r0 = vrise_cnt;
        f0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        cycles(20);
        n_checks++;
        if (fe_cnt !== f0 + 1) begin
            n_fail++;
            $display("FAIL framing_pulse: got %0d pulses, want 1", fe_cnt - f0);
        end
        n_checks++;
        if (vrise_cnt !== r0 || data_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL framing_no_valid: got %0d rises v=%b, want 0", vrise_cnt - r0,
                     data_out_valid);
        end
        send_frame(8'h55, 1'b1);
        cycles(5);
        n_checks++;
        if (data_out !== 8'h55 || data_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL framing_recover: got %h v=%b, want 55 v=1", data_out, data_out_valid);
        end
        pulse_ready();
    endtask

    task automatic test_overrun();
        int o0;
        o0 = ov_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        cycles(5);
        n_checks++;
        if (data_out !== 8'h11 || data_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_keep: got %h v=%b, want 11 v=1", data_out, data_out_valid);
        end
        n_checks++;
        if (ov_cnt !== o0 + 1) begin
            n_fail++;
            $display("FAIL overrun_pulse: got %0d pulses, want 1", ov_cnt - o0);
        end
        pulse_ready();
        n_checks++;
        if (data_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_accept: got v=%b, want 0", data_out_valid);
        end
    endtask

    task automatic test_midframe_reset();
        int r0, f0, o0;
        r0 = vrise_cnt;
        f0 = fe_cnt;
        o0 = ov_cnt;
        serial_in = 1'b0;
        cycles(10);
        serial_in = 1'b1;
        cycles(45);
        rst_n = 1'b0;
        cycles(3);
        n_checks++;
        if (busy !== 1'b0 || data_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state: got busy=%b v=%b, want 0 0", busy, data_out_valid);
        end
        rst_n = 1'b1;
        cycles(80);
        send_frame(8'h0F, 1'b1);
        cycles(5);
        n_checks++;
        if (data_out !== 8'h0F || data_out_valid !== 1'b1 || vrise_cnt !== r0 + 1) begin
            n_fail++;
            $display("FAIL midreset_byte: got %h v=%b rises=%0d, want 0f v=1 rises=1",
                     data_out, data_out_valid, vrise_cnt - r0);
        end
        n_checks++;
        if (fe_cnt !== f0 || ov_cnt !== o0) begin
            n_fail++;
            $display("FAIL midreset_errors: got fe=%0d ov=%0d, want 0 0", fe_cnt - f0,
                     ov_cnt - o0);
        end
        pulse_ready();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_overrun();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
